// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns engine: accepts a 128-bit state and
// produces one 32-bit column per cycle over four cycles. Valid/ready
// handshakes on both sides, with one block in flight at a time.

// GF(2^8) multiplier, polynomial x^8+x^4+x^3+x+1. Purely combinational.
module gal8_mul (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    logic [7:0] acc;
    logic [7:0] sh;

    // Shift-and-add over the bits of b, reducing a by the AES polynomial at each step.
    always_comb begin
        // NOTE: every variable written here is given a value before any
        // conditional use, so no latch can be inferred.
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        p = acc;
    end
endmodule

module mix_columns_seq #(
    parameter int unsigned INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q;
    logic [127:0] src_q;
    logic         mode_q;
    logic [127:0] out_q;
    logic         accept;
    logic         use_inv;
    logic [31:0]  src_word;
    logic [7:0]   a_col [4];
    logic [7:0]   coef  [4][4];
    logic [7:0]   prod  [4][4];
    logic [31:0]  b_col;

    // Base coefficient row; output row r uses it rotated right by r.
    function automatic logic [7:0] coef_of(input logic inv, input logic [1:0] k);
        case (k)
            2'd0:    return inv ? 8'h0e : 8'h02;
            2'd1:    return inv ? 8'h0b : 8'h03;
            2'd2:    return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    assign accept    = in_valid && (state_q == IDLE);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign state_out = out_q;

    // With INV_EN = 0 the coefficients are constant forward values, so the
    // multipliers reduce to the forward-only constant multipliers.
    assign use_inv = (INV_EN != 0) && mode_q;

    // Select the source column addressed by the column counter.
    always_comb begin
        case (col_q)
            2'd0:    src_word = src_q[127:96];
            2'd1:    src_word = src_q[95:64];
            2'd2:    src_word = src_q[63:32];
            default: src_word = src_q[31:0];
        endcase
        a_col[0] = src_word[31:24];
        a_col[1] = src_word[23:16];
        a_col[2] = src_word[15:8];
        a_col[3] = src_word[7:0];
    end

    // Four multipliers per output row; each row's products XOR into one byte.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            assign coef[r][j] = coef_of(use_inv, 2'(j - r));
            gal8_mul u_mul (
                .a(coef[r][j]),
                .b(a_col[j]),
                .p(prod[r][j])
            );
        end
        assign b_col[31-8*r -: 8] = prod[r][0] ^ prod[r][1] ^ prod[r][2] ^ prod[r][3];
    end

    // Next-state logic: accept in IDLE, four column cycles in BUSY, hold in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (col_q == 2'd3) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Source capture; only loaded on accept.
    always_ff @(posedge clk) begin
        // NOTE: src_q has no reset: it is only read in BUSY, which can be
        // reached only through an accept that loads it.
        if (accept) src_q <= state_in;
    end

    // Column counter, latched mode and per-column result write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= 2'd0;
            mode_q <= 1'b0;
            out_q  <= '0;
        end else if (accept) begin
            col_q  <= 2'd0;
            mode_q <= (INV_EN != 0) ? inv_i : 1'b0;
        end else if (state_q == BUSY) begin
            col_q <= col_q + 2'd1;
            case (col_q)
                2'd0:    out_q[127:96] <= b_col;
                2'd1:    out_q[95:64]  <= b_col;
                2'd2:    out_q[63:32]  <= b_col;
                default: out_q[31:0]   <= b_col;
            endcase
        end
    end
endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Sequential AES MixColumns / InvMixColumns engine that consumes a full 128-bit state and processes one 32-bit column per cycle.
- Sits directly downstream of ShiftRows in the round datapath and feeds AddRoundKey.
- Built from gal8_mul instances over GF(2^8) with polynomial x^8+x^4+x^3+x+1; four multipliers per output row, reused across columns.
- Valid/ready handshake on both sides; one block in flight at a time.

Parameters:
- INV_EN, 1, 1 = inverse mode supported via inv_i; 0 = inv_i ignored, forward only (inverse multipliers not instantiated).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  state_in/inv_i valid
- in_ready  output  1  engine can accept a block
- state_in  input  128  input state; byte k = state_in[127-8k -: 8]; column c = bytes 4c..4c+3 (column 0 in [127:96], row 0 in the MSB byte)
- inv_i  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with state_in
- out_valid  output  1  state_out valid
- out_ready  input  1  downstream accepts state_out
- state_out  output  128  result, same byte ordering as state_in

Behaviour:
- Reset (synchronous, active-high, applies mid-operation): FSM to IDLE, col counter 0, out_valid 0, state_out 0, latched mode 0. in_ready is 1 in the first cycle after reset deasserts. Any in-flight block is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: latch state_in into the src register and inv_i into the mode register (forced 0 when INV_EN = 0); col <= 0; go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle computes column col from src and writes it to state_out bytes 4col..4col+3.
  - col increments each cycle. On col == 3, after the write, go to DONE.
  - Exactly 4 BUSY cycles per block.
- Forward mode, per column (a0..a3 -> b0..b3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Inverse mode: same structure with coefficient rows {0e,0b,0d,09}, rotated right by one per output row.
- All products come from gal8_mul. XOR sums are 8-bit, with no carries.
- DONE:
  - out_valid = 1, in_ready = 0.
  - state_out is held stable until the handshake.
  - On out_ready: go to IDLE. out_valid is 0 from the next cycle.
  - state_out retains its last value in IDLE.
- Latency: input accepted at edge N gives out_valid high after edge N+4. Minimum issue interval is 6 cycles (accept, 4 BUSY, 1 DONE with out_ready already high).
- Simultaneous events:
  - in_valid while in BUSY or DONE is ignored (no accept, since in_ready = 0). Upstream must hold its data.
  - out_ready held high before DONE has no effect.
  - out_ready deasserted in DONE stalls indefinitely with no data change.
- Mode is per block. Changing inv_i during BUSY does not affect the block in flight.
- The col counter is 2 bits and never wraps mid-block; it is reset to 0 on each accept.

Test Plan:
- Forward FIPS-197 vector: state_in = db135345_f20a225c_01010101_2d26314c, inv_i=0, out_ready=1 -> state_out = 8e4da1bc_9fdc589d_01010101_4d7ebdf8; out_valid rises 4 edges after accept and is high for exactly 1 cycle.
- Inverse round-trip: state_in = 8e4da1bc_9fdc589d_01010101_4d7ebdf8, inv_i=1 -> state_out = db135345_f20a225c_01010101_2d26314c. A second case with c6c6c6c6_d4d4d4d5_... gives c6c6c6c6 in column 0 and d5d5d7d6 in column 1 (forward).
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1, state_out stable, in_ready 0. Raise out_ready -> IDLE next cycle, in_ready 1.
- Input ignored while busy: assert in_valid with different data during BUSY -> no accept, result unchanged. The held block is accepted when in_ready returns, and its result is correct.
- Reset mid-operation: assert rst during the second BUSY cycle -> next cycle out_valid=0, state_out=0, in_ready=1. A fresh block afterwards produces the correct result.
- INV_EN=0 build: inv_i=1 with the forward vector -> forward result 8e4da1bc_... is produced.
